axi4_sram_bridge: RTL and testbench

//  AXI4 slave that turns AXI4 bursts into single-cycle SRAM bank accesses.

---
 rtl/axi4_sram_bridge_if.sv | 79 +++++++
 rtl/axi4_sram_bridge.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axi4_sram_bridge.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_sram_bridge_if.sv
// AXI4 channel bundle between the interconnect and the SRAM bridge.
// AW/W/B/AR/R signals; slave and master modports.
interface axi4_sram_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 5,
  parameter int USER_W = 4
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic [USER_W-1:0]   aw_user;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic [USER_W-1:0]   w_user;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic [USER_W-1:0]   b_user;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic [USER_W-1:0]   ar_user;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [USER_W-1:0]   r_user;
  logic                r_valid;
  logic                r_ready;

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size,
    input  aw_burst, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size,
    input  ar_burst, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last,
    output r_user, r_valid,
    input  r_ready
  );

  modport master (
    output aw_id, aw_addr, aw_len, aw_size,
    output aw_burst, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size,
    output ar_burst, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last,
    input  r_user, r_valid,
    output r_ready
  );
endinterface

// File: rtl/axi4_sram_bridge.sv
// AXI4 slave turning bursts into single-cycle SRAM bank accesses.
// Ports: clk_i, rst_i, axi (slave), bank_addr/cs/we/be/wdata out, bank_rdata in.
module axi4_sram_bridge #(
  parameter int AXI_ADDR_WIDTH       = 32,
  parameter int AXI_DATA_WIDTH       = 32,
  parameter int AXI_ID_WIDTH         = 5,
  parameter int AXI_USER_WIDTH       = 4,
  parameter int SRAM_BANKS_ROWS      = 1,
  parameter int SRAM_BANKS_COLS      = 1,
  parameter int SRAM_BANK_ADDR_WIDTH = 32,
  parameter int SRAM_BANK_DATA_WIDTH = 32,
  parameter int SRAM_READ_LATENCY    = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  axi4_sram_bridge_if.slave axi,
  output logic [SRAM_BANK_ADDR_WIDTH-1:0] bank_addr,
  output logic [SRAM_BANKS_ROWS-1:0]
               [SRAM_BANKS_COLS-1:0] bank_cs,
  output logic [SRAM_BANKS_ROWS-1:0]
               [SRAM_BANKS_COLS-1:0] bank_we,
  output logic [SRAM_BANKS_ROWS-1:0]
               [SRAM_BANKS_COLS-1:0]
               [SRAM_BANK_DATA_WIDTH/8-1:0] bank_be,
  output logic [SRAM_BANKS_COLS-1:0]
               [SRAM_BANK_DATA_WIDTH-1:0] bank_wdata,
  input  logic [SRAM_BANKS_ROWS-1:0]
               [SRAM_BANKS_COLS-1:0]
               [SRAM_BANK_DATA_WIDTH-1:0] bank_rdata
);
  localparam int AW    = AXI_ADDR_WIDTH;
  localparam int DW    = AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int OFF   = $clog2(SW);
  localparam int ROWS  = SRAM_BANKS_ROWS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int L     = SRAM_READ_LATENCY;
  localparam int DEPTH = L + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE, WRITE, WRESP, READ
  } state_t;

  state_t state_q, state_d;

  logic                    prio_wr_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [AW-1:0]           addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [8:0]              icnt_q;
  logic [7:0]              rcnt_q;
  logic [CNT_W-1:0]        occ_q;
  logic [CNT_W-1:0]        fcnt_q;
  logic [PTR_W-1:0]        wp_q, rp_q;
  logic                    pend_q [L];
  logic [ROW_W-1:0]        prow_q [L];
  logic [DW-1:0]           fifo_q [DEPTH];

  logic          aw_rdy, ar_rdy, w_rdy;
  logic          b_vld, r_vld, r_last_c;
  logic          pop, push, rd_issue;
  logic          acc, acc_we;
  logic [AW-1:0] acc_addr, acc_word;
  logic [SW-1:0] acc_be;
  logic [DW-1:0] acc_wdata, rdata_word;
  logic [ROW_W-1:0] acc_row;
  logic          unused_ok;

  function automatic logic [AW-1:0] next_addr(
    input logic [AW-1:0] a,
    input logic [7:0]    len,
    input logic [2:0]    size,
    input logic [1:0]    burst
  );
    logic [AW-1:0] step, mask;
    step = AW'(1) << size;
    mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    unique case (1'b1)
      burst == 2'b00: return a;
      burst == 2'b10: return (a & ~mask) | ((a + step) & mask);
      default:        return a + step;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push     = pend_q[L-1];
  assign r_last_c = (rcnt_q == len_q);
  assign acc_word = acc_addr >> OFF;
  assign acc_row  = ROW_W'(acc_word % AW'(ROWS));
  assign rdata_word = bank_rdata[prow_q[L-1]];

  always_comb begin
    state_d   = state_q;
    aw_rdy    = 1'b0;
    ar_rdy    = 1'b0;
    w_rdy     = 1'b0;
    b_vld     = 1'b0;
    r_vld     = 1'b0;
    pop       = 1'b0;
    rd_issue  = 1'b0;
    acc       = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_be    = '0;
    acc_wdata = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          ar_rdy = axi.ar_valid &&
                   (!prio_wr_q || !axi.aw_valid);
          aw_rdy = axi.aw_valid &&
                   (prio_wr_q || !axi.ar_valid);
          // first read beat issues in the AR handshake cycle
          if (ar_rdy) begin
            state_d  = READ;
            rd_issue = 1'b1;
            acc      = 1'b1;
            acc_addr = axi.ar_addr;
            acc_be   = '1;
          end else if (aw_rdy) begin
            state_d = WRITE;
          end
        end
        WRITE: begin
          w_rdy = 1'b1;
          if (axi.w_valid) begin
            acc       = 1'b1;
            acc_we    = 1'b1;
            acc_addr  = addr_q;
            acc_be    = axi.w_strb;
            acc_wdata = axi.w_data;
            if (axi.w_last) state_d = WRESP;
          end
        end
        WRESP: begin
          b_vld = 1'b1;
          if (axi.b_ready) state_d = IDLE;
        end
        READ: begin
          r_vld = (fcnt_q != '0);
          pop   = r_vld && axi.r_ready;
          // occupancy counts in-flight plus buffered beats
          if (icnt_q <= {1'b0, len_q} &&
              (occ_q < CNT_W'(DEPTH) || pop)) begin
            rd_issue = 1'b1;
            acc      = 1'b1;
            acc_addr = addr_q;
            acc_be   = '1;
          end
          if (pop && r_last_c) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bank_cs    = '0;
    bank_we    = '0;
    bank_be    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    if (acc) begin
      bank_cs[acc_row] = '1;
      bank_we[acc_row] = {SRAM_BANKS_COLS{acc_we}};
      bank_be[acc_row] = acc_be;
      bank_addr  = SRAM_BANK_ADDR_WIDTH'(acc_word / AW'(ROWS));
      bank_wdata = acc_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      icnt_q    <= '0;
      rcnt_q    <= '0;
      occ_q     <= '0;
      fcnt_q    <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      for (int i = 0; i < L; i++) begin
        pend_q[i] <= 1'b0;
        prow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      // pointer moves only on contested grants: loser wins next
      if (axi.aw_valid && axi.ar_valid && (aw_rdy || ar_rdy))
        prio_wr_q <= ar_rdy;
      if (ar_rdy) begin
        id_q    <= axi.ar_id;
        len_q   <= axi.ar_len;
        size_q  <= axi.ar_size;
        burst_q <= axi.ar_burst;
        addr_q  <= next_addr(axi.ar_addr, axi.ar_len,
                             axi.ar_size, axi.ar_burst);
        rcnt_q  <= '0;
      end else if (aw_rdy) begin
        id_q    <= axi.aw_id;
        len_q   <= axi.aw_len;
        size_q  <= axi.aw_size;
        burst_q <= axi.aw_burst;
        addr_q  <= axi.aw_addr;
      end else if (acc) begin
        addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
      end
      if (rd_issue) icnt_q <= ar_rdy ? 9'd1 : icnt_q + 9'd1;
      if (pop) rcnt_q <= rcnt_q + 8'd1;
      case ({rd_issue, pop})
        2'b10:   occ_q <= occ_q + CNT_W'(1);
        2'b01:   occ_q <= occ_q - CNT_W'(1);
        default: occ_q <= occ_q;
      endcase
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + CNT_W'(1);
        2'b01:   fcnt_q <= fcnt_q - CNT_W'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      if (push) wp_q <= ptr_inc(wp_q);
      if (pop)  rp_q <= ptr_inc(rp_q);
      pend_q[0] <= rd_issue;
      prow_q[0] <= acc_row;
      for (int i = 1; i < L; i++) begin
        pend_q[i] <= pend_q[i-1];
        prow_q[i] <= prow_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wp_q] <= rdata_word;
  end

  assign axi.aw_ready = aw_rdy;
  assign axi.ar_ready = ar_rdy;
  assign axi.w_ready  = w_rdy;
  assign axi.b_valid  = b_vld;
  assign axi.b_id     = id_q;
  assign axi.b_resp   = 2'b00;
  assign axi.b_user   = AXI_USER_WIDTH'(0);
  assign axi.r_valid  = r_vld;
  assign axi.r_id     = id_q;
  assign axi.r_data   = r_vld ? fifo_q[rp_q] : '0;
  assign axi.r_resp   = 2'b00;
  assign axi.r_last   = r_vld && r_last_c;
  assign axi.r_user   = '0;

  assign unused_ok = ^{axi.aw_user, axi.w_user, axi.ar_user};
endmodule

// File: tb/tb_axi4_sram_bridge.sv
// Directed bench for axi4_sram_bridge with a 2-cycle SRAM model.
// Covers arbitration, bursts, strobes, R backpressure, WRAP, reset.
module tb_axi4_sram_bridge;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_i;

  logic [31:0]            bank_addr;
  logic [0:0][0:0]        bank_cs;
  logic [0:0][0:0]        bank_we;
  logic [0:0][0:0][3:0]   bank_be;
  logic [0:0][31:0]       bank_wdata;
  logic [0:0][0:0][31:0]  bank_rdata;

  axi4_sram_bridge_if #(
    .ADDR_W(32), .DATA_W(32), .ID_W(5), .USER_W(4)
  ) axi_if ();

  axi4_sram_bridge #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
    .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(4),
    .SRAM_BANKS_ROWS(1), .SRAM_BANKS_COLS(1),
    .SRAM_BANK_ADDR_WIDTH(32), .SRAM_BANK_DATA_WIDTH(32),
    .SRAM_READ_LATENCY(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .axi(axi_if),
    .bank_addr(bank_addr),
    .bank_cs(bank_cs),
    .bank_we(bank_we),
    .bank_be(bank_be),
    .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
  );

  // SRAM model: data visible two cycles after a read select
  logic [31:0] mem [0:1023];
  logic [31:0] p0, p1;
  logic        clr_mem;
  always @(posedge clk_i) begin
    if (clr_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (bank_cs[0][0] && bank_we[0][0]) begin
      for (int b = 0; b < 4; b++)
        if (bank_be[0][0][b])
          mem[bank_addr[9:0]][b*8 +: 8] <= bank_wdata[0][b*8 +: 8];
    end
    p0 <= (bank_cs[0][0] && !bank_we[0][0]) ?
          mem[bank_addr[9:0]] : 32'hBAD0BAD0;
    p1 <= p0;
  end
  assign bank_rdata[0][0] = p1;

  int total = 0;
  int bad = 0;
  logic [31:0] rd_data [16];
  bit          rd_last [16];
  logic [4:0]  rd_id [16];
  int got, first_cyc, last_cyc;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic aw_set(input logic [4:0] id, input logic [31:0] a,
                        input logic [7:0] len, input logic [1:0] bt);
    axi_if.aw_id    = id;
    axi_if.aw_addr  = a;
    axi_if.aw_len   = len;
    axi_if.aw_size  = 3'd2;
    axi_if.aw_burst = bt;
    axi_if.aw_valid = 1'b1;
  endtask

  task automatic ar_set(input logic [4:0] id, input logic [31:0] a,
                        input logic [7:0] len, input logic [1:0] bt);
    axi_if.ar_id    = id;
    axi_if.ar_addr  = a;
    axi_if.ar_len   = len;
    axi_if.ar_size  = 3'd2;
    axi_if.ar_burst = bt;
    axi_if.ar_valid = 1'b1;
  endtask

  task automatic aw_hs();
    int n = 0;
    #1;
    while (!axi_if.aw_ready && n < 50) begin
      @(negedge clk_i); #1; n++;
    end
    chk("aw_handshake", axi_if.aw_ready, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    axi_if.aw_valid = 1'b0;
  endtask

  task automatic ar_hs();
    int n = 0;
    #1;
    while (!axi_if.ar_ready && n < 50) begin
      @(negedge clk_i); #1; n++;
    end
    chk("ar_handshake", axi_if.ar_ready, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    axi_if.ar_valid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s,
                        input bit last, input logic [31:0] exp_ba,
                        input string tag);
    int n = 0;
    axi_if.w_data  = d;
    axi_if.w_strb  = s;
    axi_if.w_last  = last;
    axi_if.w_valid = 1'b1;
    #1;
    while (!axi_if.w_ready && n < 50) begin
      @(negedge clk_i); #1; n++;
    end
    chk({tag, "_ctl"},
        {bank_cs[0][0], bank_we[0][0], bank_be[0][0]},
        {1'b1, 1'b1, s});
    chk({tag, "_addr"}, bank_addr, exp_ba);
    @(posedge clk_i);
    @(negedge clk_i);
    axi_if.w_valid = 1'b0;
    axi_if.w_last  = 1'b0;
  endtask

  task automatic b_take(input logic [4:0] id);
    int n = 0;
    axi_if.b_ready = 1'b1;
    #1;
    while (!axi_if.b_valid && n < 50) begin
      @(negedge clk_i); #1; n++;
    end
    chk("b_valid", axi_if.b_valid, 1);
    chk("b_id_resp", {axi_if.b_id, axi_if.b_resp}, {id, 2'b00});
    @(posedge clk_i);
    @(negedge clk_i);
    axi_if.b_ready = 1'b0;
  endtask

  task automatic rd_collect(input int n, input bit bp);
    got = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int c = 0; c < 200 && got < n; c++) begin
      axi_if.r_ready = bp ? (c % 2 == 0) : 1'b1;
      #1;
      if (axi_if.r_valid && axi_if.r_ready) begin
        rd_data[got] = axi_if.r_data;
        rd_last[got] = axi_if.r_last;
        rd_id[got]   = axi_if.r_id;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got++;
      end
      @(posedge clk_i);
      @(negedge clk_i);
    end
    axi_if.r_ready = 1'b0;
    chk("beat_count", got, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    clr_mem = 1'b1;
    axi_if.aw_id = '0;    axi_if.aw_addr = '0;
    axi_if.aw_len = '0;   axi_if.aw_size = '0;
    axi_if.aw_burst = '0; axi_if.aw_user = '0;
    axi_if.aw_valid = 1'b0;
    axi_if.w_data = '0;   axi_if.w_strb = '0;
    axi_if.w_last = 1'b0; axi_if.w_user = '0;
    axi_if.w_valid = 1'b0;
    axi_if.b_ready = 1'b0;
    axi_if.ar_id = '0;    axi_if.ar_addr = '0;
    axi_if.ar_len = '0;   axi_if.ar_size = '0;
    axi_if.ar_burst = '0; axi_if.ar_user = '0;
    axi_if.ar_valid = 1'b0;
    axi_if.r_ready = 1'b0;

    // both channels valid during reset; readys must stay low
    aw_set(5'd3, 32'h10, 8'd0, 2'b01);
    ar_set(5'd1, 32'h10, 8'd0, 2'b01);
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_handshake",
        {axi_if.aw_ready, axi_if.ar_ready, axi_if.w_ready,
         axi_if.b_valid, axi_if.r_valid}, 5'b0);
    chk("rst_bank_ctl",
        {bank_cs[0][0], bank_we[0][0], bank_be[0][0]}, 6'b0);
    chk("rst_bank_addr", bank_addr, 32'h0);
    chk("rst_bank_wdata", bank_wdata, 32'h0);
    clr_mem = 1'b0;

    // simultaneous pair after reset: read first
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("arb0_ar_ready", axi_if.ar_ready, 1);
    chk("arb0_aw_ready", axi_if.aw_ready, 0);
    ar_hs();
    rd_collect(1, 1'b0);
    chk("rd0_data", rd_data[0], 32'h0);
    chk("rd0_last_id", {rd_last[0], rd_id[0]}, {1'b1, 5'd1});
    chk("rd0_latency", first_cyc, 2);
    aw_hs();
    w_beat(32'hDEADBEEF, 4'hF, 1'b1, 32'h4, "w0");
    b_take(5'd3);

    // next simultaneous pair: write first
    aw_set(5'd2, 32'h20, 8'd0, 2'b01);
    ar_set(5'd3, 32'h10, 8'd0, 2'b01);
    #1;
    chk("arb1_aw_ready", axi_if.aw_ready, 1);
    chk("arb1_ar_ready", axi_if.ar_ready, 0);
    aw_hs();
    w_beat(32'hFFFFFFFF, 4'hF, 1'b1, 32'h8, "w1");
    b_take(5'd2);
    ar_hs();
    rd_collect(1, 1'b0);
    chk("rd1_data", rd_data[0], 32'hDEADBEEF);
    chk("rd1_last_id", {rd_last[0], rd_id[0]}, {1'b1, 5'd3});

    // byte strobes over a preloaded word
    aw_set(5'd4, 32'h20, 8'd0, 2'b01);
    aw_hs();
    w_beat(32'h0, 4'h5, 1'b1, 32'h8, "wstrb");
    b_take(5'd4);
    ar_set(5'd5, 32'h20, 8'd0, 2'b01);
    ar_hs();
    rd_collect(1, 1'b0);
    chk("strb_data", rd_data[0], 32'hFF00FF00);

    // INCR burst of four
    aw_set(5'd6, 32'h100, 8'd3, 2'b01);
    aw_hs();
    for (int i = 0; i < 4; i++)
      w_beat(32'(i + 1), 4'hF, i == 3, 32'h40 + 32'(i), "wincr");
    b_take(5'd6);
    ar_set(5'd6, 32'h100, 8'd3, 2'b01);
    ar_hs();
    rd_collect(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("incr_data", rd_data[i], 64'(i + 1));
      chk("incr_last", rd_last[i], 64'(i == 3));
    end
    chk("incr_latency", first_cyc, 2);
    chk("incr_rate", last_cyc - first_cyc, 3);

    // eight beats read back under R backpressure
    aw_set(5'd7, 32'h200, 8'd7, 2'b01);
    aw_hs();
    for (int i = 0; i < 8; i++)
      w_beat(32'hA0 + 32'(i), 4'hF, i == 7, 32'h80 + 32'(i), "wbp");
    b_take(5'd7);
    ar_set(5'd7, 32'h200, 8'd7, 2'b01);
    ar_hs();
    rd_collect(8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("bp_data", rd_data[i], 64'(32'hA0 + 32'(i)));
      chk("bp_last", rd_last[i], 64'(i == 7));
    end

    // WRAP write visits 0x38,0x3C,0x30,0x34
    aw_set(5'd8, 32'h38, 8'd3, 2'b10);
    aw_hs();
    w_beat(32'h11, 4'hF, 1'b0, 32'hE, "wwrap0");
    w_beat(32'h22, 4'hF, 1'b0, 32'hF, "wwrap1");
    w_beat(32'h33, 4'hF, 1'b0, 32'hC, "wwrap2");
    w_beat(32'h44, 4'hF, 1'b1, 32'hD, "wwrap3");
    b_take(5'd8);
    ar_set(5'd8, 32'h30, 8'd3, 2'b01);
    ar_hs();
    rd_collect(4, 1'b0);
    chk("wrap_d0", rd_data[0], 32'h33);
    chk("wrap_d1", rd_data[1], 32'h44);
    chk("wrap_d2", rd_data[2], 32'h11);
    chk("wrap_d3", rd_data[3], 32'h22);

    // reset in the middle of a stalled read burst
    ar_set(5'd9, 32'h200, 8'd7, 2'b01);
    ar_hs();
    axi_if.r_ready = 1'b0;
    repeat (4) @(negedge clk_i);
    #1;
    chk("mid_rvalid_pre", axi_if.r_valid, 1);
    aw_set(5'd1, 32'h40, 8'd0, 2'b01);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_handshake",
        {axi_if.aw_ready, axi_if.ar_ready, axi_if.w_ready,
         axi_if.b_valid, axi_if.r_valid}, 5'b0);
    chk("mid_rst_cs", bank_cs[0][0], 0);
    @(negedge clk_i);
    axi_if.aw_valid = 1'b0;
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    #1;
    chk("mid_rvalid_post", axi_if.r_valid, 0);
    @(negedge clk_i);
    ar_set(5'd10, 32'h10, 8'd0, 2'b01);
    ar_hs();
    rd_collect(1, 1'b0);
    chk("post_rst_data", rd_data[0], 32'hDEADBEEF);
    chk("post_rst_id", rd_id[0], 5'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
